axi_slv_mem: RTL and testbench

Synthesizable AXI slave responder backed by a word-addressed memory array. It is the responding end of the AXI bus driven through the master side of the VIP interface, and serves as the DUT/target behind the VIP master agent. Independent write (AW/W/B) and read (AR/R) engines each handle one outstanding burst, supporting FIXED, INCR and WRAP bursts with byte strobes.

---
 rtl/axi_slv_mem.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_axi_slv_mem.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slv_mem.sv
// axi_slv_mem: AXI slave backed by a word-addressed memory array.
// Independent write (AW/W/B) and read (AR/R) engines each carry one
// outstanding FIXED/INCR/WRAP burst; writes honour byte strobes.
//
// Ports
//   ACLK, ARESETn                 clock, async active-low reset
//   AW*  / AWREADY                write address channel (AWPROT ignored)
//   W*   / WREADY                 write data channel (WID ignored)
//   BID, BRESP, BVALID / BREADY   write response
//   AR*  / ARREADY                read address channel (ARPROT ignored)
//   RID, RDATA, RRESP, RLAST, RVALID / RREADY   read data
//
// state  | meaning
// W_IDLE | AWREADY high, waiting for a write address
// W_DATA | WREADY high, accepting beats until count == LEN
// W_RESP | BVALID high, waiting for BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high, presenting the current beat
module axi_slv_mem #(
    parameter int D_ID_WIDTH   = 4,
    parameter int D_ADDR_WIDTH = 32,
    parameter int D_DATA_WIDTH = 32,
    parameter int MEM_DEPTH    = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [D_ID_WIDTH-1:0]     AWID,
    input  logic [D_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic [2:0]                AWPROT,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [D_ID_WIDTH-1:0]     WID,
    input  logic [D_DATA_WIDTH-1:0]   WDATA,
    input  logic [D_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [D_ID_WIDTH-1:0]     BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [D_ID_WIDTH-1:0]     ARID,
    input  logic [D_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic [2:0]                ARSIZE,
    input  logic [1:0]                ARBURST,
    input  logic [2:0]                ARPROT,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [D_ID_WIDTH-1:0]     RID,
    output logic [D_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY
);

    localparam int STRB_W   = D_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [D_ADDR_WIDTH-1:0] DEPTH_A = D_ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [D_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic unused_ok;
    assign unused_ok = ^{WID, AWPROT, ARPROT};

    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        return (size > 3'(ADDR_LSB)) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) &&
                !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
    endfunction

    function automatic logic in_range(input logic [D_ADDR_WIDTH-1:0] addr);
        return (addr >> ADDR_LSB) < DEPTH_A;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [D_ADDR_WIDTH-1:0] addr);
        return IDX_W'(addr >> ADDR_LSB);
    endfunction

    // WRAP keeps the upper bits of the (LEN+1)*bytes window and wraps the low bits.
    function automatic logic [D_ADDR_WIDTH-1:0] next_addr(input logic [D_ADDR_WIDTH-1:0] addr,
                                                          input logic [7:0] len,
                                                          input logic [2:0] size,
                                                          input logic [1:0] burst);
        logic [D_ADDR_WIDTH-1:0] bytes;
        logic [D_ADDR_WIDTH-1:0] incr;
        logic [D_ADDR_WIDTH-1:0] wmask;
        bytes = D_ADDR_WIDTH'(1) << size;
        incr  = (addr & ~(bytes - D_ADDR_WIDTH'(1))) + bytes;
        wmask = ((D_ADDR_WIDTH'(len) + D_ADDR_WIDTH'(1)) << size) - D_ADDR_WIDTH'(1);
        if (burst == BURST_FIXED)     return addr;
        else if (burst == BURST_WRAP) return (addr & ~wmask) | (incr & wmask);
        else                          return incr;
    endfunction

    // ---------------- write engine ----------------
    w_state_t                w_state_q, w_state_d;
    logic                    awready_q, awready_d;
    logic [D_ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [D_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]              w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]              w_size_q, w_size_d;
    logic [1:0]              w_burst_q, w_burst_d;
    logic                    w_err_q, w_err_d;
    logic                    mem_we;
    logic                    w_beat_ok;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        w_beat_ok = !burst_err(w_len_q, w_size_q, w_burst_q) && in_range(w_addr_q);
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID && awready_q) begin
                    w_id_d    = AWID;
                    w_addr_d  = AWADDR;
                    w_len_d   = AWLEN;
                    w_size_d  = AWSIZE;
                    w_burst_d = AWBURST;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID) begin
                    mem_we = w_beat_ok;
                    if (!w_beat_ok || (WLAST != (w_cnt_q == w_len_q))) w_err_d = 1'b1;
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_cnt_q == w_len_q) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (WSTRB[i]) mem[word_idx(w_addr_q)][8*i +: 8] <= WDATA[8*i +: 8];
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = (w_state_q == W_DATA);
    assign BVALID  = (w_state_q == W_RESP);
    assign BID     = w_id_q;
    assign BRESP   = w_err_q ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read engine ----------------
    r_state_t                r_state_q, r_state_d;
    logic                    arready_q, arready_d;
    logic [D_ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [D_ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]              r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]              r_size_q, r_size_d;
    logic [1:0]              r_burst_q, r_burst_d;
    logic [D_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [D_ADDR_WIDTH-1:0] rd_addr;
    logic                    rd_ok;
    logic [D_DATA_WIDTH-1:0] rd_word;

    // Address of the beat to be loaded next: beat 0 of a new AR, or the successor.
    always_comb begin
        if (r_state_q == R_IDLE) begin
            rd_addr = ARADDR;
            rd_ok   = !burst_err(ARLEN, ARSIZE, ARBURST) && in_range(ARADDR);
        end else begin
            rd_addr = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
            rd_ok   = !burst_err(r_len_q, r_size_q, r_burst_q) && in_range(rd_addr);
        end
        rd_word = rd_ok ? mem[word_idx(rd_addr)] : '0;
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID && arready_q) begin
                    r_id_d    = ARID;
                    r_addr_d  = ARADDR;
                    r_len_d   = ARLEN;
                    r_size_d  = ARSIZE;
                    r_burst_d = ARBURST;
                    r_cnt_d   = 8'd0;
                    rdata_d   = rd_word;
                    rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = rd_addr;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        rdata_d  = rd_word;
                        rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = (r_state_q == R_DATA);
    assign RLAST   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
    assign RID     = r_id_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_slv_mem.sv
module tb_axi_slv_mem;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID, WID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_rd [16];
    logic [1:0]  exp_rr [16];

    axi_slv_mem dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_aw(input string tag);
        int c = 0;
        while (AWREADY !== 1'b1 && c < 20) begin @(negedge ACLK); c++; end
        chk({tag, "_awready_wait"}, AWREADY, 1);
    endtask

    task automatic wait_w(input string tag);
        int c = 0;
        while (WREADY !== 1'b1 && c < 20) begin @(negedge ACLK); c++; end
        chk({tag, "_wready_wait"}, WREADY, 1);
    endtask

    task automatic wait_ar(input string tag);
        int c = 0;
        while (ARREADY !== 1'b1 && c < 20) begin @(negedge ACLK); c++; end
        chk({tag, "_arready_wait"}, ARREADY, 1);
    endtask

    task automatic wait_r(input string tag);
        int c = 0;
        while (RVALID !== 1'b1 && c < 20) begin @(negedge ACLK); c++; end
        chk({tag, "_rvalid_wait"}, RVALID, 1);
    endtask

    // Called just after a falling edge; beat i carries data d0+i.
    task automatic do_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input logic [31:0] d0, input logic [3:0] strb, input logic [1:0] exp_resp);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        wait_aw(tag);
        @(negedge ACLK);
        AWVALID = 1'b0;
        chk({tag, "_awready_low"}, AWREADY, 0);
        chk({tag, "_wready_high"}, WREADY, 1);
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = d0 + 32'(i); WSTRB = strb; WLAST = (i == int'(len)); WVALID = 1'b1;
            wait_w(tag);
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk({tag, "_bvalid"}, BVALID, 1);
        chk({tag, "_wready_low"}, WREADY, 0);
        chk({tag, "_bid"}, BID, id);
        chk({tag, "_bresp"}, BRESP, exp_resp);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk({tag, "_bvalid_drop"}, BVALID, 0);
        chk({tag, "_awready_back"}, AWREADY, 1);
    endtask

    task automatic do_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        wait_ar(tag);
        @(negedge ACLK);
        ARVALID = 1'b0;
        RREADY  = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            wait_r(tag);
            chk($sformatf("%s_rdata%0d", tag, i), RDATA, exp_rd[i]);
            chk($sformatf("%s_rresp%0d", tag, i), RRESP, exp_rr[i]);
            chk($sformatf("%s_rlast%0d", tag, i), RLAST, (i == int'(len)));
            chk($sformatf("%s_rid%0d", tag, i), RID, id);
            @(negedge ACLK);
        end
        RREADY = 1'b0;
        chk({tag, "_rvalid_drop"}, RVALID, 0);
        chk({tag, "_arready_back"}, ARREADY, 1);
    endtask

    initial begin
        ARESETn = 1'b0;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWPROT = 0; AWVALID = 0;
        WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
        ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARPROT = 0; ARVALID = 0;
        RREADY = 0;
        repeat (2) @(negedge ACLK);

        // reset state
        chk("rst_handshakes", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}, 0);
        chk("rst_ids", {BID, RID}, 0);
        chk("rst_resps", {BRESP, RRESP}, 0);
        chk("rst_rdata", RDATA, 0);
        ARESETn = 1'b1;
        #1;
        chk("rst_awready_not_yet", AWREADY, 0);
        chk("rst_arready_not_yet", ARREADY, 0);
        @(negedge ACLK);
        chk("rst_awready_up", AWREADY, 1);
        chk("rst_arready_up", ARREADY, 1);

        // INCR write then INCR read back
        do_write("wr_incr", 4'd5, 32'h10, 8'd3, 3'd2, 2'd1, 32'hA0, 4'hF, OKAY);
        exp_rd[0] = 32'hA0; exp_rd[1] = 32'hA1; exp_rd[2] = 32'hA2; exp_rd[3] = 32'hA3;
        for (int i = 0; i < 4; i++) exp_rr[i] = OKAY;
        do_read("rd_incr", 4'd6, 32'h10, 8'd3, 3'd2, 2'd1);

        // WRAP read: 0x18, 0x1C, 0x10, 0x14
        exp_rd[0] = 32'hA2; exp_rd[1] = 32'hA3; exp_rd[2] = 32'hA0; exp_rd[3] = 32'hA1;
        do_read("rd_wrap", 4'd7, 32'h18, 8'd3, 3'd2, 2'd2);

        // byte strobes
        do_write("wr_ones", 4'd1, 32'h0, 8'd0, 3'd2, 2'd1, 32'hFFFF_FFFF, 4'hF, OKAY);
        do_write("wr_strb", 4'd1, 32'h0, 8'd0, 3'd2, 2'd1, 32'h0000_1200, 4'h2, OKAY);
        exp_rd[0] = 32'hFFFF_12FF; exp_rr[0] = OKAY;
        do_read("rd_strb", 4'd2, 32'h0, 8'd0, 3'd2, 2'd1);

        // out-of-range word (index 1024 would alias word 0 if truncated)
        do_write("wr_oor", 4'd3, 32'h1000, 8'd0, 3'd2, 2'd1, 32'h55, 4'hF, SLVERR);
        exp_rd[0] = 32'h0; exp_rr[0] = SLVERR;
        do_read("rd_oor", 4'd3, 32'h1000, 8'd0, 3'd2, 2'd1);
        exp_rd[0] = 32'hFFFF_12FF; exp_rr[0] = OKAY;
        do_read("rd_unchanged", 4'd4, 32'h0, 8'd0, 3'd2, 2'd1);

        // reserved burst type: SLVERR and no memory update
        do_write("wr_rsvd", 4'd4, 32'h10, 8'd1, 3'd2, 2'd3, 32'h99, 4'hF, SLVERR);
        exp_rd[0] = 32'hA0; exp_rd[1] = 32'hA1; exp_rr[0] = OKAY; exp_rr[1] = OKAY;
        do_read("rd_after_rsvd", 4'd5, 32'h10, 8'd1, 3'd2, 2'd1);

        // WRAP with LEN=2 and oversize SIZE are burst errors
        for (int i = 0; i < 3; i++) begin exp_rd[i] = 32'h0; exp_rr[i] = SLVERR; end
        do_read("rd_wrap_len2", 4'd8, 32'h10, 8'd2, 3'd2, 2'd2);
        do_read("rd_size3", 4'd8, 32'h10, 8'd0, 3'd3, 2'd1);

        // concurrent AW+AR on one edge, then stall B and R for 5 cycles
        AWID = 4'd3; AWADDR = 32'h20; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'd1; AWVALID = 1'b1;
        ARID = 4'd9; ARADDR = 32'h14; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = 2'd1; ARVALID = 1'b1;
        chk("conc_awready", AWREADY, 1);
        chk("conc_arready", ARREADY, 1);
        @(negedge ACLK);
        AWVALID = 1'b0; ARVALID = 1'b0;
        chk("conc_aw_taken", AWREADY, 0);
        chk("conc_ar_taken", ARREADY, 0);
        WDATA = 32'h77; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0; WLAST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_b%0d", k), {BVALID, BID, BRESP}, {1'b1, 4'd3, OKAY});
            chk($sformatf("stall_r%0d", k), {RVALID, RLAST, RID, RRESP}, {1'b1, 1'b1, 4'd9, OKAY});
            chk($sformatf("stall_rdata%0d", k), RDATA, 32'hA1);
            @(negedge ACLK);
        end
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0; RREADY = 1'b0;
        chk("conc_done_valid", {BVALID, RVALID}, 0);
        chk("conc_done_ready", {AWREADY, ARREADY}, 2'b11);
        exp_rd[0] = 32'h77; exp_rr[0] = OKAY;
        do_read("rd_conc", 4'd9, 32'h20, 8'd0, 3'd2, 2'd1);

        // reset in the middle of a 4-beat read
        ARID = 4'd2; ARADDR = 32'h10; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'd1; ARVALID = 1'b1;
        wait_ar("rd_abort");
        @(negedge ACLK);
        ARVALID = 1'b0; RREADY = 1'b1;
        chk("abort_beat0", RDATA, 32'hA0);
        @(negedge ACLK);
        chk("abort_beat1", {RVALID, RDATA}, {1'b1, 32'hA1});
        #2 ARESETn = 1'b0;
        #1;
        chk("abort_rvalid_async", {RVALID, RLAST}, 0);
        chk("abort_rdata_clr", RDATA, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        chk("abort_arready_low", ARREADY, 0);
        @(negedge ACLK);
        chk("abort_arready_up", ARREADY, 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("abort_no_stray%0d", k), RVALID, 0);
            @(negedge ACLK);
        end
        RREADY = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
